// File: rtl/hc_sr_echo_gen.sv
// HC-SR04 responder model: answers a valid trig pulse with an echo whose width encodes dist_cm.
// Enforces minimum trig width, burst delay, out-of-range timeout and post-echo holdoff.
module hc_sr_echo_gen #(
  parameter int TRIG_MIN   = 10,
  parameter int BURST_US   = 200,
  parameter int MIN_CM     = 2,
  parameter int MAX_CM     = 400,
  parameter int TIMEOUT_US = 38000,
  parameter int HOLDOFF_US = 10000
) (
  input  logic       clk_us,
  input  logic       Rst_n,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  localparam logic [15:0] L_TRIG_MIN   = 16'(TRIG_MIN);
  localparam logic [15:0] L_BURST_LAST = 16'(BURST_US - 1);
  localparam logic [15:0] L_HOLD_LAST  = 16'(HOLDOFF_US - 1);
  localparam logic [15:0] L_TIMEOUT    = 16'(TIMEOUT_US);
  localparam logic [8:0]  L_MIN_CM     = 9'(MIN_CM);
  localparam logic [8:0]  L_MAX_CM     = 9'(MAX_CM);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_width;
  logic        r_trig_d;
  logic        r_echo;
  logic        r_busy;
  logic        r_short;

  logic [15:0] w_d16;
  logic [15:0] w_mul58;
  logic        w_in_range;
  logic [15:0] w_width_sel;

  // d*58 as shift-and-subtract; the largest 9-bit product still fits in 16 bits.
  assign w_d16       = {7'd0, dist_cm};
  assign w_mul58     = (w_d16 << 6) - (w_d16 << 2) - (w_d16 << 1);
  assign w_in_range  = (dist_cm >= L_MIN_CM) && (dist_cm <= L_MAX_CM);
  assign w_width_sel = w_in_range ? w_mul58 : L_TIMEOUT;

  always_ff @(posedge clk_us or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_width  <= 16'd0;
      r_trig_d <= 1'b0;
      r_echo   <= 1'b0;
      r_busy   <= 1'b0;
      r_short  <= 1'b0;
    end else begin
      r_trig_d <= trig;
      r_short  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (trig && !r_trig_d) begin
            r_state <= S_TRIG_HI;
            r_cnt   <= 16'd1;
            r_busy  <= 1'b1;
          end
        end
        S_TRIG_HI: begin
          if (trig) begin
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
          end else if (r_cnt >= L_TRIG_MIN) begin
            r_width <= w_width_sel;
            r_state <= S_BURST;
            r_cnt   <= 16'd0;
          end else begin
            r_short <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
          end
        end
        S_BURST: begin
          if (r_cnt == L_BURST_LAST) begin
            r_state <= S_ECHO;
            r_cnt   <= 16'd0;
            r_echo  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_ECHO: begin
          // Width was latched at trig fall so dist_cm changes cannot stretch this pulse.
          if (r_cnt == r_width - 16'd1) begin
            r_state <= S_HOLDOFF;
            r_cnt   <= 16'd0;
            r_echo  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt == L_HOLD_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 16'd0;
          r_echo  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign echo       = r_echo;
  assign busy       = r_busy;
  assign short_trig = r_short;

endmodule

// File: tb/tb_hc_sr_echo_gen.sv
// Bench for hc_sr_echo_gen: expected echo widths are queued when a trig is issued and checked
// against the measured pulse; shortened timeout/holdoff keep the run short.
`timescale 1ns/1ps
module tb_hc_sr_echo_gen;

  localparam int P_TRIG_MIN = 10;
  localparam int P_BURST    = 200;
  localparam int P_TIMEOUT  = 3000;
  localparam int P_HOLD     = 1500;
  localparam int P_LIM      = 40000;

  logic       clk_us = 1'b0;
  logic       Rst_n  = 1'b0;
  logic       trig   = 1'b0;
  logic [8:0] dist_cm = 9'd0;
  logic       echo;
  logic       busy;
  logic       short_trig;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int short_cnt = 0;

  hc_sr_echo_gen #(
    .TRIG_MIN(P_TRIG_MIN), .BURST_US(P_BURST), .MIN_CM(2), .MAX_CM(400),
    .TIMEOUT_US(P_TIMEOUT), .HOLDOFF_US(P_HOLD)
  ) dut (
    .clk_us(clk_us), .Rst_n(Rst_n), .trig(trig), .dist_cm(dist_cm),
    .echo(echo), .busy(busy), .short_trig(short_trig)
  );

  always #5 clk_us = ~clk_us;

  always @(negedge clk_us) if (short_trig) short_cnt++;

  function automatic int model_w(input int d);
    if (d >= 2 && d <= 400) return d * 58;
    return P_TIMEOUT;
  endfunction

  // Trig high for exactly n sampled edges; returns on the negedge where trig drops.
  task automatic pulse(input int n);
    @(negedge clk_us);
    trig = 1'b1;
    repeat (n) @(negedge clk_us);
    trig = 1'b0;
  endtask

  // Measures from E0: echo rise delay, echo width, and busy-low delay after echo fall.
  task automatic measure(output int rise, output int width, output int hold);
    int c;
    rise = -1; width = -1; hold = -1;
    c = 0;
    forever begin
      @(negedge clk_us);
      if (echo) begin rise = c; break; end
      c++;
      if (c > P_LIM) return;
    end
    c = 0;
    forever begin
      @(negedge clk_us);
      c++;
      if (!echo) begin width = c; break; end
      if (c > P_LIM) return;
    end
    c = 0;
    forever begin
      @(negedge clk_us);
      c++;
      if (!busy) begin hold = c; break; end
      if (c > P_LIM) return;
    end
  endtask

  task automatic check_echo(input string tag, input int rise, input int width, input int hold);
    int exp_w;
    exp_w = -1;
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    $display("txn %s: rise=%0d width=%0d hold=%0d expected_width=%0d", tag, rise, width, hold, exp_w);
    n_vec++;
    if (rise !== P_BURST) begin
      n_err++; $display("FAIL %s_rise: got %0d want %0d", tag, rise, P_BURST);
    end
    n_vec++;
    if (width !== exp_w) begin
      n_err++; $display("FAIL %s_width: got %0d want %0d", tag, width, exp_w);
    end
    n_vec++;
    if (hold !== P_HOLD) begin
      n_err++; $display("FAIL %s_hold: got %0d want %0d", tag, hold, P_HOLD);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge clk_us);
    $display("txn reset: echo=%0b busy=%0b short=%0b", echo, busy, short_trig);
    n_vec++;
    if (echo !== 1'b0) begin n_err++; $display("FAIL reset_echo: got %0b want 0", echo); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_vec++;
    if (short_trig !== 1'b0) begin n_err++; $display("FAIL reset_short: got %0b want 0", short_trig); end
    Rst_n = 1'b1;
    repeat (2) @(negedge clk_us);
  endtask

  task automatic test_basic();
    int r, w, h;
    dist_cm = 9'd100;
    @(negedge clk_us);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %0b want 0", busy); end
    trig = 1'b1;
    @(negedge clk_us);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise: got %0b want 1", busy); end
    repeat (14) @(negedge clk_us);
    trig = 1'b0;
    exp_q.push_back(model_w(100));
    measure(r, w, h);
    check_echo("basic", r, w, h);
  endtask

  task automatic test_short_trig();
    int r, w, h, s0, seen;
    s0 = short_cnt;
    dist_cm = 9'd100;
    pulse(P_TRIG_MIN - 1);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL short_busy_hi: got %0b want 1", busy); end
    @(negedge clk_us);
    n_vec++;
    if (short_trig !== 1'b1) begin n_err++; $display("FAIL short_pulse: got %0b want 1", short_trig); end
    @(negedge clk_us);
    n_vec++;
    if (short_trig !== 1'b0) begin n_err++; $display("FAIL short_one_cycle: got %0b want 0", short_trig); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL short_busy_lo: got %0b want 0", busy); end
    seen = 0;
    repeat (300) begin @(negedge clk_us); if (echo || busy) seen++; end
    $display("txn short: short_pulses=%0d activity=%0d", short_cnt - s0, seen);
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL short_no_echo: got %0d want 0", seen); end
    n_vec++;
    if (short_cnt !== s0 + 1) begin n_err++; $display("FAIL short_count: got %0d want %0d", short_cnt, s0 + 1); end
    dist_cm = 9'd2;
    pulse(P_TRIG_MIN);
    exp_q.push_back(model_w(2));
    measure(r, w, h);
    check_echo("exact_min_d2", r, w, h);
  endtask

  task automatic test_widths();
    int dl[3] = '{400, 1, 401};
    int r, w, h;
    foreach (dl[i]) begin
      dist_cm = 9'(dl[i]);
      pulse(15);
      exp_q.push_back(model_w(dl[i]));
      measure(r, w, h);
      check_echo($sformatf("width_d%0d", dl[i]), r, w, h);
    end
  endtask

  task automatic test_ignore();
    int r, w, h, s0, seen;
    s0 = short_cnt;
    dist_cm = 9'd50;
    pulse(15);
    exp_q.push_back(model_w(50));
    fork
      begin
        repeat (400) @(negedge clk_us);
        trig = 1'b1; repeat (15) @(negedge clk_us); trig = 1'b0;
        repeat (3400) @(negedge clk_us);
        trig = 1'b1; repeat (4) @(negedge clk_us); trig = 1'b0;
      end
    join_none
    measure(r, w, h);
    check_echo("ignore", r, w, h);
    seen = 0;
    repeat (300) begin @(negedge clk_us); if (echo || busy) seen++; end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL ignore_no_restart: got %0d want 0", seen); end
    n_vec++;
    if (short_cnt !== s0) begin n_err++; $display("FAIL ignore_no_short: got %0d want %0d", short_cnt, s0); end
    pulse(15);
    exp_q.push_back(model_w(50));
    measure(r, w, h);
    check_echo("after_holdoff", r, w, h);
  endtask

  task automatic test_dist_change();
    int r, w, h;
    dist_cm = 9'd100;
    pulse(15);
    exp_q.push_back(model_w(100));
    fork
      begin repeat (50) @(negedge clk_us); dist_cm = 9'd300; end
    join_none
    measure(r, w, h);
    check_echo("dist_change", r, w, h);
  endtask

  task automatic test_reset_mid_echo();
    int r, w, h, c;
    dist_cm = 9'd100;
    pulse(15);
    c = 0;
    while (!echo && c < P_LIM) begin @(negedge clk_us); c++; end
    n_vec++;
    if (echo !== 1'b1) begin n_err++; $display("FAIL rst_mid_echo_start: got %0b want 1", echo); end
    repeat (100) @(negedge clk_us);
    Rst_n = 1'b0;
    #1;
    $display("txn reset_mid_echo: echo=%0b busy=%0b", echo, busy);
    n_vec++;
    if (echo !== 1'b0) begin n_err++; $display("FAIL rst_mid_echo: got %0b want 0", echo); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %0b want 0", busy); end
    @(negedge clk_us);
    Rst_n = 1'b1;
    dist_cm = 9'd10;
    pulse(15);
    exp_q.push_back(model_w(10));
    measure(r, w, h);
    check_echo("post_reset", r, w, h);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_trig();
    test_widths();
    test_ignore();
    test_dist_change();
    test_reset_mid_echo();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
